// File: rtl/universal_shift_register.sv
// universal_shift_register
//   WIDTH-bit shift/rotate/load register with a burst engine. A burst repeats
//   one latched operation COUNT times. It uses a start/busy/done handshake, so
//   no per-cycle control is needed while it runs.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   en     : single-step enable, ignored while busy
//   mode   : operation select (hold/shl/shr/rol/ror/asr/load/clr)
//   sin    : serial input bit for the shift modes
//   pdata  : parallel load data
//   start  : burst request, sampled only when idle
//   count  : burst length (number of operations)
//   q      : register contents (registered)
//   sout   : next bit to leave the register (combinational)
//   busy   : high while a burst is running (registered)
//   done   : one-cycle pulse at burst completion (registered)
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  // Operation encoding
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // Burst engine states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state,    state_d;
  logic [2:0]       mode_q,   mode_d;
  logic [CNT_W-1:0] remaining, remaining_d;
  logic [WIDTH-1:0] q_d;
  logic             busy_d;
  logic             done_d;
  logic [2:0]       sout_mode;

  // One application of an operation to the current register value
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             s,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      MODE_HOLD: r = cur;
      MODE_SHL:  r = {cur[WIDTH-2:0], s};
      MODE_SHR:  r = {s, cur[WIDTH-1:1]};
      MODE_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:  r = {cur[0], cur[WIDTH-1:1]};
      MODE_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      MODE_LOAD: r = ld;
      MODE_CLR:  r = '0;
      default:   r = cur;
    endcase
    return r;
  endfunction

  // Hold, load and clear give the same result when repeated, so a burst of
  // any of them runs as a single operation.
  function automatic logic is_idempotent(input logic [2:0] op);
    return (op == MODE_HOLD) || (op == MODE_LOAD) || (op == MODE_CLR);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_HOLD;
      remaining <= '0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      mode_q    <= mode_d;
      remaining <= remaining_d;
      q         <= q_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d     = state;
    mode_d      = mode_q;
    remaining_d = remaining;
    q_d         = q;
    busy_d      = busy;
    done_d      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          // A start request takes priority over a single-step enable
          if (count != '0) begin
            mode_d      = mode;
            remaining_d = is_idempotent(mode) ? CNT_W'(1) : count;
            busy_d      = 1'b1;
            state_d     = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          q_d = apply_op(mode, q, sin, pdata);
        end
      end

      ST_RUN: begin
        // sin and pdata stay live during a burst; only the mode is latched
        q_d         = apply_op(mode_q, q, sin, pdata);
        remaining_d = remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Bit that the selected operation pushes out next
  always_comb begin
    sout_mode = (state == ST_RUN) ? mode_q : mode;
    case (sout_mode)
      MODE_SHL, MODE_ROL:           sout = q[WIDTH-1];
      MODE_SHR, MODE_ROR, MODE_ASR: sout = q[0];
      default:                      sout = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register. It runs directed scenarios followed by
// randomized traffic. All of it is compared every cycle against a
// queue-based reference model.
module tb_universal_shift_register;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic          sin;
  logic [W-1:0]  pdata;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  q;
  logic          sout;
  logic          busy;
  logic          done;

  universal_shift_register #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pdata(pdata),
    .start(start), .count(count), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_seen;

  // Reference model: register value, done flag, and a queue of pending ops
  logic [W-1:0] m_q;
  logic         m_done;
  int           m_ops[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] cur,
                                          input logic s, input logic [W-1:0] ld);
    int v;
    int mask;
    v    = int'(cur);
    mask = (1 << W) - 1;
    case (op)
      1: return W'(((v * 2) + int'(s)) & mask);
      2: return W'((v / 2) + (int'(s) << (W - 1)));
      3: return W'(((v * 2) & mask) + (v >> (W - 1)));
      4: return W'((v / 2) + ((v % 2) << (W - 1)));
      5: return W'($signed(cur) >>> 1);
      6: return ld;
      7: return '0;
      default: return cur;
    endcase
  endfunction

  function automatic logic ref_sout(input int op, input logic [W-1:0] cur);
    if (op == 1 || op == 3) return cur[W-1];
    if (op == 2 || op == 4 || op == 5) return cur[0];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_done = 1'b0;
    m_ops.delete();
  endtask

  // One clock: check sout before the edge, advance the model, check registers
  task automatic tick();
    logic          c_en, c_start, c_sin;
    logic [2:0]    c_mode;
    logic [W-1:0]  c_pdata;
    logic [CW-1:0] c_count;
    int            op;
    int            n;
    #1;
    op = (m_ops.size() != 0) ? m_ops[0] : int'(mode);
    check("sout", 32'(sout), 32'(ref_sout(op, m_q)));
    c_en = en; c_start = start; c_sin = sin;
    c_mode = mode; c_pdata = pdata; c_count = count;
    @(posedge clk);
    #1;
    if (m_ops.size() != 0) begin
      op     = m_ops.pop_front();
      m_q    = ref_op(op, m_q, c_sin, c_pdata);
      m_done = (m_ops.size() == 0);
    end else begin
      m_done = 1'b0;
      if (c_start) begin
        if (c_count == '0) m_done = 1'b1;
        else begin
          n = (c_mode == 3'd0 || c_mode == 3'd6 || c_mode == 3'd7) ? 1 : int'(c_count);
          repeat (n) m_ops.push_back(int'(c_mode));
        end
      end else if (c_en) begin
        m_q = ref_op(int'(c_mode), m_q, c_sin, c_pdata);
      end
    end
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_ops.size() != 0));
    check("done", 32'(done), 32'(m_done));
    if (done) done_seen++;
  endtask

  // Assert reset asynchronously, hold for a number of edges, release on negedge
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_q", 32'(q), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    mode = 3'd6; pdata = v; en = 1'b1; start = 1'b0;
    tick();
    en = 1'b0;
  endtask

  // Start a burst, then run until busy drops; returns number of op edges
  task automatic burst(input logic [2:0] m, input logic [CW-1:0] n, output int ops);
    mode = m; count = n; start = 1'b1;
    tick();
    start = 1'b0;
    ops = 0;
    while (busy && ops < 40) begin
      en   = 1'($urandom);
      sin  = 1'($urandom);
      mode = 3'($urandom);
      tick();
      ops++;
    end
    en = 1'b0;
  endtask

  int ops;
  logic [W-1:0] asr_exp[3];

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'd0; sin = 1'b0; pdata = '0;
    start = 1'b0; count = '0;
    model_reset();
    #2;

    // Reset held for 5 cycles
    do_reset(5);
    #1;
    check("post_rst_q", 32'(q), 32'h00);
    check("post_rst_sout", 32'(sout), 32'(0));

    // Parallel load, then one shift left with sin=1
    load(8'hA5);
    check("load_a5", 32'(q), 32'hA5);
    mode = 3'd1; sin = 1'b1; en = 1'b1;
    #1;
    check("shl_sout_before", 32'(sout), 32'(1));
    tick();
    en = 1'b0;
    check("shl_4b", 32'(q), 32'h4B);

    // 4-op rotate-left burst from 0xA5
    load(8'hA5);
    done_seen = 0;
    burst(3'd3, 4'd4, ops);
    check("rol_ops", 32'(ops), 32'(4));
    check("rol_busy_edges", 32'(ops + 1), 32'(5));
    check("rol_q", 32'(q), 32'h5A);
    check("rol_done_now", 32'(done), 32'(1));
    tick();
    check("rol_done_once", 32'(done_seen), 32'(1));

    // Arithmetic shift right burst from 0x80
    load(8'h80);
    asr_exp[0] = 8'hC0; asr_exp[1] = 8'hE0; asr_exp[2] = 8'hF0;
    mode = 3'd5; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("asr_step", 32'(q), 32'(asr_exp[i]));
    end
    tick();
    check("asr_done_once", 32'(done_seen), 32'(1));

    // Zero-length burst: done next cycle, no busy, q unchanged
    mode = 3'd1; count = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cnt0_done", 32'(done), 32'(1));
    check("cnt0_busy", 32'(busy), 32'(0));
    check("cnt0_q", 32'(q), 32'hF0);

    // A second start during a 4-op burst is ignored
    done_seen = 0;
    mode = 3'd4; count = 4'd4; start = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 4 && busy; i++) tick();
    tick();
    check("restart_ignored", 32'(done_seen), 32'(1));

    // Reset after the 2nd op edge of a 5-op SHR burst, then a fresh burst
    load(8'h3C);
    done_seen = 0;
    mode = 3'd2; sin = 1'b1; count = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    do_reset(1);
    tick();
    check("abort_no_done", 32'(done_seen), 32'(0));
    load(8'h81);
    burst(3'd4, 4'd2, ops);
    check("fresh_ops", 32'(ops), 32'(2));
    check("fresh_done", 32'(done_seen), 32'(1));

    // Randomized traffic, including long counts and occasional resets
    for (int i = 0; i < 600; i++) begin
      en    = 1'($urandom);
      mode  = 3'($urandom);
      sin   = 1'($urandom);
      pdata = W'($urandom);
      count = CW'($urandom);
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 120) == 0) do_reset(1);
      else tick();
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
